// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared state encoding for the bit-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

   // 2'd3 is unused; the FSM default branch recovers it to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/fa.sv
`default_nettype none
// ============================================================================
// Module  : fa
// Brief   : Single-bit full adder cell (combinational).
// Revision: 1.0 - initial release
// ============================================================================
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic c
);

   assign s = a ^ b ^ cin;
   assign c = (a & b) | (cin & (a ^ b));

endmodule : fa
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial WIDTH-bit adder. One operand bit pair per clock, LSB
//           first, through a single full-adder cell with a carry flip-flop.
//           start/busy/done handshake; result registered and held.
// Revision: 1.0 - initial release
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] res_next;   // {s, res_sh[WIDTH-1:1]}: result register after this bit
   logic             load;

   assign load = (state == ST_IDLE) && start;

   fa u_fa (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (carry),
      .s   (fa_s),
      .c   (fa_c)
   );

   // Only the upper WIDTH-1 bits of the result shift register are ever read
   // back, so the register is kept at that width; WIDTH=1 needs none at all.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_next = fa_s;
      end else begin : g_res_wn
         logic [WIDTH-2:0] res_hi;

         // Partial-result shift register: cleared on load, shifts in s each RUN edge
         always_ff @(posedge clk) begin
            if (rst) begin
               res_hi <= '0;
            end else if (load) begin
               res_hi <= '0;
            end else if (state == ST_RUN) begin
               res_hi <= res_next[WIDTH-1:1];
            end
         end

         assign res_next = {fa_s, res_hi};
      end
   endgenerate

   // Control FSM, operand shifters, carry FF and held result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         count <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  count <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               carry <= fa_c;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               count <= count + CW'(1);
               if (count == LAST_BIT) begin
                  // Outputs move only here, so they never expose partial sums.
                  sum   <= res_next;
                  cout  <= fa_c;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule : serial_adder
`default_nettype wire
